label_allocator: RTL
====================

LABEL_ALLOCATOR -- requirements
Module: label_allocator

Interface
REQ-001 SHALL have parameter MEM_BASE, default 16'h0000: first word address handed out after reset or clear.
REQ-002 SHALL have parameter MEM_END, default 17'h10000: exclusive upper bound of allocatable word space.
REQ-003 SHALL have port clk, input, 1: single clock; all state changes on rising edge.
REQ-004 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port req_valid, input, 1: allocation request present.
REQ-006 SHALL have port req_ready, output, 1: allocator accepts request this cycle.
REQ-007 SHALL have port req_lbid, input, 12: label ID to define.
REQ-008 SHALL have port req_typ, input, 8: element type code (0x01 VPtr, 0x02-0x07 8/16/32-bit, 0x08-0x0D 4/2/1-bit, 0x86 Code).
REQ-009 SHALL have port req_count, input, 16: element count.
REQ-010 SHALL have port clear, input, 1: free all allocations.
REQ-011 SHALL have ports lbidw (12), typw (8), basew (16), countw (16) and we (1), all outputs: write port into the label table.
REQ-012 SHALL have ports resp_valid (1), resp_err (1) and resp_base (16), all outputs: completion report.

Function
REQ-013 SHALL implement FSM IDLE -> CALC -> {WRITE | ERR} -> IDLE.
REQ-014 SHALL assert req_ready only in IDLE with clear low; a handshake is req_valid && req_ready.
REQ-015 On handshake, SHALL latch lbid, typ and count, then move to CALC.
REQ-016 In CALC, SHALL compute words = ceil(count*bits/32) at 21-bit width with no truncation, where bits = 32 for 0x01, 0x06, 0x07 and 0x86; 16 for 0x04-0x05; 8 for 0x02-0x03; 4, 2, 1 for 0x08/09, 0x0A/0B, 0x0C/0D.
REQ-017 In CALC, SHALL go to ERR if typ is 0x00 or any unlisted code, or if ptr + words > MEM_END at 22-bit compare; otherwise SHALL go to WRITE.
REQ-018 In WRITE, SHALL for exactly one cycle drive we=1, lbidw=lbid, typw=typ, basew=ptr[15:0], countw=count, resp_valid=1, resp_err=0 and resp_base=ptr[15:0].
REQ-019 In WRITE, SHALL update ptr <= ptr + words (17 bits).
REQ-020 In ERR, SHALL for one cycle drive resp_valid=1, resp_err=1, resp_base=0 and we=0, leaving ptr unchanged.
REQ-021 Latency SHALL be fixed: handshake in cycle N, we/resp_valid in cycle N+2, next req_ready in cycle N+3.
REQ-022 A count of 0 SHALL give words=0: the entry is written with base=ptr and ptr is unchanged.
REQ-023 An exact fill (ptr + words == MEM_END) SHALL succeed and leave ptr=MEM_END; any later nonzero request SHALL return an error.
REQ-024 clear SHALL be sampled only in IDLE and set ptr <= MEM_BASE; clear outside IDLE SHALL be ignored.
REQ-025 When clear and req_valid are both high in IDLE, clear SHALL win and the request SHALL NOT be accepted.
REQ-026 Redefining an existing lbid SHALL allocate fresh space; old space SHALL NOT be reclaimed.
REQ-027 Outside WRITE/ERR, we, resp_valid and resp_err SHALL be 0; lbidw/typw/basew/countw SHALL hold the latched values.

Reset
REQ-028 On rst_n low, SHALL immediately force state=IDLE, ptr=MEM_BASE, we=0, resp_valid=0, resp_err=0, resp_base=0 and latched fields=0, aborting any operation in flight with no table write.
REQ-029 SHALL assert req_ready in the first cycle after rst_n deasserts.

Structure
REQ-030 Type codes, the FSM state encoding and the bits-per-type function SHALL live in shared package label_pkg, also used by the label table and the decoder.
REQ-031 Size computation SHALL be a combinational sub-module label_size_calc (typ, count -> words[20:0], invalid).

Verification
REQ-032 After reset, request typ=0x06, count=10, then typ=0x03, count=5 -> writes with base 0x0000 and 0x000A, ptr ends at 0x000C.
REQ-033 Request typ=0x0D, count=33 -> words=2, base as expected; typ=0x00 -> resp_err=1, we never asserted.
REQ-034 Set ptr to 0xFFF0, request typ=0x06, count=16 -> success, ptr=0x10000; then count=1 -> resp_err=1.
REQ-035 clear and req_valid high together in IDLE -> req_ready=0, no write, and next request gets base=MEM_BASE.
REQ-036 Drop rst_n during CALC -> we stays 0, ptr=MEM_BASE, req_ready=1 after release.
REQ-037 Back-to-back req_valid held high -> handshakes exactly 3 cycles apart, each with one we pulse.

Source files
------------

// File: rtl/label_pkg.sv
// label_pkg: shared definitions for the label allocator, label table and decoder.
//   - element type codes
//   - allocator FSM state encoding
//   - typ_bits(): storage bits per element for a type code (0 = unknown code)
package label_pkg;

  localparam int LBID_W  = 12;
  localparam int TYP_W   = 8;
  localparam int CNT_W   = 16;
  localparam int ADDR_W  = 16;
  localparam int WORDS_W = 21;

  typedef enum logic [TYP_W-1:0] {
    TYP_NONE = 8'h00,
    TYP_VPTR = 8'h01,
    TYP_8A   = 8'h02,
    TYP_8B   = 8'h03,
    TYP_16A  = 8'h04,
    TYP_16B  = 8'h05,
    TYP_32A  = 8'h06,
    TYP_32B  = 8'h07,
    TYP_4A   = 8'h08,
    TYP_4B   = 8'h09,
    TYP_2A   = 8'h0A,
    TYP_2B   = 8'h0B,
    TYP_1A   = 8'h0C,
    TYP_1B   = 8'h0D,
    TYP_CODE = 8'h86
  } label_typ_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_WRITE,
    ST_ERR
  } alloc_state_e;

  // Bits per element; 0 flags a code the allocator must reject.
  function automatic logic [5:0] typ_bits(input logic [TYP_W-1:0] typ);
    case (typ)
      TYP_VPTR, TYP_32A, TYP_32B, TYP_CODE: typ_bits = 6'd32;
      TYP_16A, TYP_16B:                     typ_bits = 6'd16;
      TYP_8A, TYP_8B:                       typ_bits = 6'd8;
      TYP_4A, TYP_4B:                       typ_bits = 6'd4;
      TYP_2A, TYP_2B:                       typ_bits = 6'd2;
      TYP_1A, TYP_1B:                       typ_bits = 6'd1;
      default:                              typ_bits = 6'd0;
    endcase
  endfunction

endpackage

// File: rtl/label_allocator_if.sv
// label_allocator_if: request handshake, clear, label-table write port and
// completion report of the label allocator.
//   slave  : allocator side (consumes requests, drives table write + response)
//   master : requester side
interface label_allocator_if;
  import label_pkg::*;

  logic                req_valid;
  logic                req_ready;
  logic [LBID_W-1:0]   req_lbid;
  logic [TYP_W-1:0]    req_typ;
  logic [CNT_W-1:0]    req_count;
  logic                clear;

  logic [LBID_W-1:0]   lbidw;
  logic [TYP_W-1:0]    typw;
  logic [ADDR_W-1:0]   basew;
  logic [CNT_W-1:0]    countw;
  logic                we;

  logic                resp_valid;
  logic                resp_err;
  logic [ADDR_W-1:0]   resp_base;

  modport slave (
    input  req_valid, req_lbid, req_typ, req_count, clear,
    output req_ready, lbidw, typw, basew, countw, we,
    output resp_valid, resp_err, resp_base
  );

  modport master (
    output req_valid, req_lbid, req_typ, req_count, clear,
    input  req_ready, lbidw, typw, basew, countw, we,
    input  resp_valid, resp_err, resp_base
  );

endinterface

// File: rtl/label_size_calc.sv
// label_size_calc: combinational word count for an allocation.
//   typ, count -> words = ceil(count * bits / 32), invalid = unknown type code
module label_size_calc
  import label_pkg::*;
(
  input  logic [TYP_W-1:0]   typ,
  input  logic [CNT_W-1:0]   count,
  output logic [WORDS_W-1:0] words,
  output logic               invalid
);

  logic [5:0]  bits;
  logic [21:0] prod;
  logic [21:0] rnd;

  assign bits    = typ_bits(typ);
  assign invalid = (bits == 6'd0);
  // 65535*32 + 31 = 2^21-1, so 22 bits hold the rounded product without loss.
  assign prod    = 22'(count) * 22'(bits);
  assign rnd     = prod + 22'd31;
  assign words   = {4'd0, rnd[21:5]};

endmodule

// File: rtl/label_allocator.sv
// label_allocator: bump allocator handing out word space to labels.
//   clk, rst_n : clock, async active-low reset
//   bus        : label_allocator_if.slave (request, clear, table write, response)
// Each accepted request takes IDLE -> CALC -> WRITE|ERR -> IDLE, so a result
// appears two cycles after the handshake and the next request is accepted one
// cycle after that. Space is never reclaimed except by clear.
module label_allocator
  import label_pkg::*;
#(
  parameter logic [15:0] MEM_BASE = 16'h0000,
  parameter logic [16:0] MEM_END  = 17'h10000
)(
  input  logic              clk,
  input  logic              rst_n,
  label_allocator_if.slave  bus
);

  alloc_state_e        state;
  logic [16:0]         ptr;
  logic [LBID_W-1:0]   lbid_q;
  logic [TYP_W-1:0]    typ_q;
  logic [CNT_W-1:0]    count_q;
  logic [ADDR_W-1:0]   base_q;
  logic                we_q;
  logic                rv_q;
  logic                re_q;
  logic [ADDR_W-1:0]   rb_q;

  logic [WORDS_W-1:0]  words;
  logic                invalid;
  logic [21:0]         end_addr;
  logic                overflow;

  label_size_calc u_size (
    .typ     (typ_q),
    .count   (count_q),
    .words   (words),
    .invalid (invalid)
  );

  // 22-bit sum so a huge request can never wrap past MEM_END.
  assign end_addr = 22'(ptr) + 22'(words);
  assign overflow = end_addr > 22'(MEM_END);

  // clear has priority: a request is never accepted in a clear cycle.
  assign bus.req_ready  = (state == ST_IDLE) && !bus.clear;

  assign bus.lbidw      = lbid_q;
  assign bus.typw       = typ_q;
  assign bus.basew      = base_q;
  assign bus.countw     = count_q;
  assign bus.we         = we_q;
  assign bus.resp_valid = rv_q;
  assign bus.resp_err   = re_q;
  assign bus.resp_base  = rb_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      ptr     <= {1'b0, MEM_BASE};
      lbid_q  <= '0;
      typ_q   <= '0;
      count_q <= '0;
      base_q  <= '0;
      we_q    <= 1'b0;
      rv_q    <= 1'b0;
      re_q    <= 1'b0;
      rb_q    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.clear) begin
            ptr <= {1'b0, MEM_BASE};
          end else if (bus.req_valid) begin
            lbid_q  <= bus.req_lbid;
            typ_q   <= bus.req_typ;
            count_q <= bus.req_count;
            state   <= ST_CALC;
          end
        end
        ST_CALC: begin
          // Outputs are registered here so they line up with the WRITE/ERR cycle.
          if (invalid || overflow) begin
            state <= ST_ERR;
            rv_q  <= 1'b1;
            re_q  <= 1'b1;
            rb_q  <= '0;
          end else begin
            state  <= ST_WRITE;
            we_q   <= 1'b1;
            rv_q   <= 1'b1;
            re_q   <= 1'b0;
            rb_q   <= ptr[15:0];
            base_q <= ptr[15:0];
          end
        end
        ST_WRITE: begin
          ptr   <= end_addr[16:0];
          we_q  <= 1'b0;
          rv_q  <= 1'b0;
          re_q  <= 1'b0;
          rb_q  <= '0;
          state <= ST_IDLE;
        end
        ST_ERR: begin
          rv_q  <= 1'b0;
          re_q  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
